// File: rtl/audio_out_pkg.sv
// Shared width helpers for the multi-channel 1-bit audio output stage.
package audio_out_pkg;

   function automatic int unsigned frame_width(int unsigned channels, int unsigned sample_w);
      return channels * sample_w;
   endfunction

   function automatic int unsigned level_width(int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Midscale of an offset-binary sample: silence with no DC step at start-up.
   function automatic int unsigned midscale(int unsigned sample_w);
      return 1 << (sample_w - 1);
   endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Single-clock frame FIFO: wrap-bit pointers, registered full flag, live level.
module audio_frame_fifo
   import audio_out_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          aclr_n,
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = level_width(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             do_wr, do_rd;
   logic [LVL_W-1:0] level_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      level    = wr_ptr_q - rd_ptr_q;
      do_wr    = wr_en && !full_q;
      do_rd    = rd_en && (level != '0);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
      level_d  = wr_ptr_d - rd_ptr_d;
      full_d   = (level_d == LVL_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign full    = full_q;
   assign empty   = (level == '0);

endmodule

// File: rtl/audio_multi_pwm_out.sv
// N-channel PCM to 1-bit audio output: frame FIFO, period tick, PWM per channel.
// Define AUDIO_SIGMA_DELTA_EN to replace the PWM compare with first-order delta-sigma.
module audio_multi_pwm_out
   import audio_out_pkg::*;
#(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned SAMPLE_W   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                           clk_audio,
   input  logic                           aclr_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHANNELS*SAMPLE_W-1:0]   in_frame,
   output logic                           fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           frame_strobe,
   output logic                           underrun,
   output logic [CHANNELS-1:0]            audio_out
);
   localparam int unsigned           FRAME_W  = frame_width(CHANNELS, SAMPLE_W);
   localparam logic [SAMPLE_W-1:0]   MIDSCALE = SAMPLE_W'(midscale(SAMPLE_W));

   logic [SAMPLE_W-1:0]                tick_q, tick_d;
   logic [CHANNELS-1:0][SAMPLE_W-1:0]  active_q, active_d;
   logic                               frame_strobe_q, frame_strobe_d;
   logic                               underrun_q, underrun_d;
   logic [CHANNELS-1:0]                audio_out_q, audio_out_d;
   logic [FRAME_W-1:0]                 head_frame;
   logic                               fifo_empty;
   logic                               period_end, pop;

   audio_frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_audio),
      .aclr_n  (aclr_n),
      .wr_en   (in_valid),
      .wr_data (in_frame),
      .rd_en   (period_end),
      .rd_data (head_frame),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      period_end     = &tick_q;
      pop            = period_end && !fifo_empty;
      tick_d         = tick_q + SAMPLE_W'(1);
      active_d       = pop ? head_frame : active_q;
      frame_strobe_d = pop;
      underrun_d     = period_end && fifo_empty;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
`ifdef AUDIO_SIGMA_DELTA_EN
      // Only the low bits persist; the carry out is the output bit itself.
      logic [SAMPLE_W-1:0] acc_q;
      logic [SAMPLE_W:0]   acc_d;

      assign acc_d          = {1'b0, acc_q} + {1'b0, active_q[c]};
      assign audio_out_d[c] = acc_d[SAMPLE_W];

      always_ff @(posedge clk_audio or negedge aclr_n) begin
         if (!aclr_n) acc_q <= '0;
         else         acc_q <= acc_d[SAMPLE_W-1:0];
      end
`else
      assign audio_out_d[c] = (tick_q < active_q[c]);
`endif
   end

   always_ff @(posedge clk_audio or negedge aclr_n) begin
      if (!aclr_n) begin
         tick_q         <= '0;
         active_q       <= {CHANNELS{MIDSCALE}};
         frame_strobe_q <= 1'b0;
         underrun_q     <= 1'b0;
         audio_out_q    <= '0;
      end else begin
         tick_q         <= tick_d;
         active_q       <= active_d;
         frame_strobe_q <= frame_strobe_d;
         underrun_q     <= underrun_d;
         audio_out_q    <= audio_out_d;
      end
   end

   assign in_ready     = !fifo_full;
   assign frame_strobe = frame_strobe_q;
   assign underrun     = underrun_q;
   assign audio_out    = audio_out_q;

endmodule

// File: tb/tb_audio_multi_pwm_out.sv
// Directed bench for audio_multi_pwm_out (CHANNELS=2, SAMPLE_W=8, FIFO_DEPTH=4).
module tb_audio_multi_pwm_out;
   logic        clk_audio;
   logic        aclr_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_frame;
   logic        fifo_full;
   logic [2:0]  fifo_level;
   logic        frame_strobe;
   logic        underrun;
   logic [1:0]  audio_out;

   int checks   = 0;
   int failures = 0;

   logic [7:0] tb_tick;
   logic [255:0] win_bits0;
   int ones0, ones1, strobes, underruns;

   audio_multi_pwm_out #(
      .CHANNELS   (2),
      .SAMPLE_W   (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_audio    (clk_audio),
      .aclr_n       (aclr_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_frame     (in_frame),
      .fifo_full    (fifo_full),
      .fifo_level   (fifo_level),
      .frame_strobe (frame_strobe),
      .underrun     (underrun),
      .audio_out    (audio_out)
   );

   // Clock and reference period counter
   initial clk_audio = 1'b0;
   always #5 clk_audio = ~clk_audio;

   always @(posedge clk_audio or negedge aclr_n) begin
      if (!aclr_n) tb_tick <= 8'd0;
      else         tb_tick <= tb_tick + 8'd1;
   end

   task automatic wait_tick(input logic [7:0] t);
      int n = 0;
      @(negedge clk_audio);
      while (tb_tick != t && n < 600) begin
         @(negedge clk_audio);
         n++;
      end
      if (tb_tick != t) begin
         checks++; failures++;
         $display("FAIL wait_tick: reached %0d, required %0d", tb_tick, t);
      end
   endtask

   // Samples the current negedge plus the next 255.
   task automatic count_window();
      ones0 = 0; ones1 = 0; strobes = 0; underruns = 0;
      for (int i = 0; i < 256; i++) begin
         if (i != 0) @(negedge clk_audio);
         win_bits0[i] = audio_out[0];
         ones0     += int'(audio_out[0]);
         ones1     += int'(audio_out[1]);
         strobes   += int'(frame_strobe);
         underruns += int'(underrun);
      end
   endtask

   task automatic push_one(input logic [15:0] f);
      in_valid = 1'b1;
      in_frame = f;
      @(negedge clk_audio);
      in_valid = 1'b0;
   endtask

   task automatic check_idle_window(input string tag);
      count_window();
      checks += 4;
      if (ones0 !== 128)  begin failures++; $display("FAIL %s ones0: got %0d, required 128", tag, ones0); end
      if (ones1 !== 128)  begin failures++; $display("FAIL %s ones1: got %0d, required 128", tag, ones1); end
      if (underruns !== 1) begin failures++; $display("FAIL %s underrun count: got %0d, required 1", tag, underruns); end
      if (strobes !== 0)  begin failures++; $display("FAIL %s strobe count: got %0d, required 0", tag, strobes); end
   endtask

   task automatic test_reset();
      aclr_n = 1'b0; in_valid = 1'b0; in_frame = 16'd0;
      repeat (3) @(negedge clk_audio);
      checks += 6;
      if (audio_out !== 2'b00)  begin failures++; $display("FAIL reset audio_out: got %b, required 00", audio_out); end
      if (fifo_level !== 3'd0)  begin failures++; $display("FAIL reset fifo_level: got %0d, required 0", fifo_level); end
      if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
      if (fifo_full !== 1'b0)   begin failures++; $display("FAIL reset fifo_full: got %b, required 0", fifo_full); end
      if (frame_strobe !== 1'b0) begin failures++; $display("FAIL reset frame_strobe: got %b, required 0", frame_strobe); end
      if (underrun !== 1'b0)    begin failures++; $display("FAIL reset underrun: got %b, required 0", underrun); end
      aclr_n = 1'b1;
   endtask

   task automatic test_idle();
      @(negedge clk_audio);
      check_idle_window("idle");
   endtask

   task automatic test_full_scale();
      wait_tick(8'd10);
      push_one({8'd0, 8'd255});
      checks++;
      if (fifo_level !== 3'd1) begin failures++; $display("FAIL full_scale level after push: got %0d, required 1", fifo_level); end
      wait_tick(8'd0);
      checks += 3;
      if (frame_strobe !== 1'b1) begin failures++; $display("FAIL full_scale strobe: got %b, required 1", frame_strobe); end
      if (underrun !== 1'b0)     begin failures++; $display("FAIL full_scale underrun: got %b, required 0", underrun); end
      if (fifo_level !== 3'd0)   begin failures++; $display("FAIL full_scale level after pop: got %0d, required 0", fifo_level); end
      @(negedge clk_audio);
      count_window();
      checks += 4;
      if (ones0 !== 255)   begin failures++; $display("FAIL full_scale L ones: got %0d, required 255", ones0); end
      if (ones1 !== 0)     begin failures++; $display("FAIL full_scale R ones: got %0d, required 0", ones1); end
      if (underruns !== 1) begin failures++; $display("FAIL full_scale underrun count: got %0d, required 1", underruns); end
      if (strobes !== 0)   begin failures++; $display("FAIL full_scale strobe count: got %0d, required 0", strobes); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] f [5];
      f[0] = {8'd40, 8'd200};
      f[1] = {8'd10, 8'd20};
      f[2] = {8'd77, 8'd33};
      f[3] = {8'd5,  8'd250};
      f[4] = {8'd99, 8'd1};
      wait_tick(8'd20);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_frame = f[i];
         @(negedge clk_audio);
      end
      in_frame = f[4];
      checks += 3;
      if (fifo_level !== 3'd4) begin failures++; $display("FAIL b2b level full: got %0d, required 4", fifo_level); end
      if (in_ready !== 1'b0)   begin failures++; $display("FAIL b2b in_ready full: got %b, required 0", in_ready); end
      if (fifo_full !== 1'b1)  begin failures++; $display("FAIL b2b fifo_full: got %b, required 1", fifo_full); end
      wait_tick(8'd255);
      checks++;
      if (fifo_level !== 3'd4) begin failures++; $display("FAIL b2b level held: got %0d, required 4", fifo_level); end
      // Valid is still held here: pop happens, push refused on the same edge.
      @(negedge clk_audio);
      checks += 3;
      if (fifo_level !== 3'd3)   begin failures++; $display("FAIL b2b level after pop: got %0d, required 3", fifo_level); end
      if (in_ready !== 1'b1)     begin failures++; $display("FAIL b2b in_ready after pop: got %b, required 1", in_ready); end
      if (frame_strobe !== 1'b1) begin failures++; $display("FAIL b2b strobe: got %b, required 1", frame_strobe); end
      @(negedge clk_audio);
      checks += 2;
      if (fifo_level !== 3'd4) begin failures++; $display("FAIL b2b fifth accepted: got %0d, required 4", fifo_level); end
      if (in_ready !== 1'b0)   begin failures++; $display("FAIL b2b in_ready refull: got %b, required 0", in_ready); end
      in_valid = 1'b0;
      count_window();
      checks += 5;
      if (ones0 !== 200)   begin failures++; $display("FAIL b2b f0 L ones: got %0d, required 200", ones0); end
      if (ones1 !== 40)    begin failures++; $display("FAIL b2b f0 R ones: got %0d, required 40", ones1); end
      if (strobes !== 1)   begin failures++; $display("FAIL b2b strobe count: got %0d, required 1", strobes); end
      if (underruns !== 0) begin failures++; $display("FAIL b2b underrun count: got %0d, required 0", underruns); end
      if (fifo_level !== 3'd3) begin failures++; $display("FAIL b2b level after second pop: got %0d, required 3", fifo_level); end
   endtask

   task automatic test_push_pop_same_cycle();
      wait_tick(8'd255);
      checks++;
      if (fifo_level !== 3'd3) begin failures++; $display("FAIL pushpop level before: got %0d, required 3", fifo_level); end
      in_valid = 1'b1;
      in_frame = {8'd128, 8'd64};
      @(negedge clk_audio);
      in_valid = 1'b0;
      checks += 3;
      if (fifo_level !== 3'd3)   begin failures++; $display("FAIL pushpop level after: got %0d, required 3", fifo_level); end
      if (frame_strobe !== 1'b1) begin failures++; $display("FAIL pushpop strobe: got %b, required 1", frame_strobe); end
      if (fifo_full !== 1'b0)    begin failures++; $display("FAIL pushpop fifo_full: got %b, required 0", fifo_full); end
   endtask

   task automatic test_mid_reset();
      wait_tick(8'd100);
      aclr_n = 1'b0;
      #1;
      checks += 5;
      if (audio_out !== 2'b00)   begin failures++; $display("FAIL midreset audio_out: got %b, required 00", audio_out); end
      if (fifo_level !== 3'd0)   begin failures++; $display("FAIL midreset fifo_level: got %0d, required 0", fifo_level); end
      if (in_ready !== 1'b1)     begin failures++; $display("FAIL midreset in_ready: got %b, required 1", in_ready); end
      if (fifo_full !== 1'b0)    begin failures++; $display("FAIL midreset fifo_full: got %b, required 0", fifo_full); end
      if (frame_strobe !== 1'b0) begin failures++; $display("FAIL midreset frame_strobe: got %b, required 0", frame_strobe); end
      repeat (2) @(negedge clk_audio);
      aclr_n = 1'b1;
      @(negedge clk_audio);
      check_idle_window("after_reset");
      checks++;
      if (fifo_level !== 3'd0) begin failures++; $display("FAIL midreset contents lost: got %0d, required 0", fifo_level); end
   endtask

   task automatic test_small_values();
      push_one({8'd1, 8'd64});
      wait_tick(8'd0);
      checks++;
      if (frame_strobe !== 1'b1) begin failures++; $display("FAIL small strobe: got %b, required 1", frame_strobe); end
      @(negedge clk_audio);
      count_window();
      checks += 2;
      if (ones0 !== 64) begin failures++; $display("FAIL small L ones: got %0d, required 64", ones0); end
      if (ones1 !== 1)  begin failures++; $display("FAIL small R ones: got %0d, required 1", ones1); end
   endtask

`ifdef AUDIO_SIGMA_DELTA_EN
   task automatic test_sigma_delta();
      int bad = 0;
      push_one({8'd0, 8'd64});
      wait_tick(8'd0);
      @(negedge clk_audio);
      count_window();
      for (int i = 0; i < 252; i++) if (win_bits0[i] != win_bits0[i+4]) bad++;
      checks += 3;
      if (ones0 !== 64) begin failures++; $display("FAIL sd ch0 ones: got %0d, required 64", ones0); end
      if (ones1 !== 0)  begin failures++; $display("FAIL sd ch1 ones: got %0d, required 0", ones1); end
      if (bad !== 0)    begin failures++; $display("FAIL sd period4 violations: got %0d, required 0", bad); end
   endtask
`endif

   initial begin
      test_reset();
      test_idle();
      test_full_scale();
      test_back_to_back();
      test_push_pop_same_cycle();
      test_mid_reset();
      test_small_values();
`ifdef AUDIO_SIGMA_DELTA_EN
      test_sigma_delta();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
